// File: rtl/coin_filter_pkg.sv
// Shared definitions for the coin-key debounce filter: per-key FSM state
// encoding (one-hot) and the key index map used by the top-level arbiter.
package coin_filter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_PRESS_FLT = 4'b0010,
        ST_DOWN      = 4'b0100,
        ST_REL_FLT   = 4'b1000
    } flt_state_t;

    localparam int NUM_KEYS = 2;
    localparam int KEY_ONE  = 0;
    localparam int KEY_HALF = 1;

endpackage

// File: rtl/coin_key_filter_if.sv
// Coin button inputs and money pulse outputs of the coin key filter.
// master = the side pressing buttons and consuming pulses, slave = the filter.
interface coin_key_filter_if;

    logic key_one_in;
    logic key_half_in;
    logic po_money_one;
    logic po_money_half;

    modport master (
        output key_one_in,
        output key_half_in,
        input  po_money_one,
        input  po_money_half
    );

    modport slave (
        input  key_one_in,
        input  key_half_in,
        output po_money_one,
        output po_money_half
    );

endinterface

// File: rtl/key_filter.sv
// One active-low key: 2-flop synchronizer followed by a press/release debounce
// FSM; emits a single registered press_pulse per accepted press.
module key_filter
    import coin_filter_pkg::*;
#(
    parameter int CNT_MAX = 999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic press_pulse
);

    localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    logic             sync1_reg;
    logic             sync2_reg;
    flt_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;

    // Reset lands in DOWN so a key held through reset must first be seen released.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            state_reg <= ST_DOWN;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            sync1_reg <= key_in;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!sync2_reg) begin
                        state_reg <= ST_PRESS_FLT;
                        cnt_reg   <= '0;
                    end
                end
                ST_PRESS_FLT: begin
                    if (sync2_reg) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_DOWN;
                        press_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (sync2_reg) begin
                        state_reg <= ST_REL_FLT;
                        cnt_reg   <= '0;
                    end
                end
                ST_REL_FLT: begin
                    if (!sync2_reg) begin
                        state_reg <= ST_DOWN;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_DOWN;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign press_pulse = press_reg;

endmodule

// File: rtl/coin_key_filter.sv
// Two debounced coin keys with pending flags and one-pulse-per-cycle arbitration
// (1-yuan wins). Define COIN_ARB_DEFER_EN to defer a losing half pulse by a cycle.
module coin_key_filter
    import coin_filter_pkg::*;
#(
    parameter int CNT_MAX = 999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    coin_key_filter_if.slave   coin
);

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] press;

    assign key_raw[KEY_ONE]  = coin.key_one_in;
    assign key_raw[KEY_HALF] = coin.key_half_in;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_filter #(
                .CNT_MAX (CNT_MAX)
            ) u_filter (
                .sys_clk     (sys_clk),
                .sys_rst     (sys_rst),
                .key_in      (key_raw[gi]),
                .press_pulse (press[gi])
            );
        end
    endgenerate

    logic pend_one_reg;
    logic pend_half_reg;
    logic pend_one_next;
    logic pend_half_next;
    logic issue_one;
    logic issue_half;
    logic po_one_reg;
    logic po_half_reg;

    // A press arriving this cycle is eligible for issue in the same cycle.
    always_comb begin
        pend_one_next  = pend_one_reg | press[KEY_ONE];
        pend_half_next = pend_half_reg | press[KEY_HALF];
        issue_one      = pend_one_next;
        issue_half     = pend_half_next & ~pend_one_next;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pend_one_reg  <= 1'b0;
            pend_half_reg <= 1'b0;
            po_one_reg    <= 1'b0;
            po_half_reg   <= 1'b0;
        end else begin
            po_one_reg    <= issue_one;
            po_half_reg   <= issue_half;
            pend_one_reg  <= pend_one_next & ~issue_one;
`ifdef COIN_ARB_DEFER_EN
            pend_half_reg <= pend_half_next & ~issue_half;
`else
            pend_half_reg <= pend_half_next & ~issue_half & ~issue_one;
`endif
        end
    end

    assign coin.po_money_one  = po_one_reg;
    assign coin.po_money_half = po_half_reg;

endmodule

// File: doc/coin_key_filter.md
COIN_KEY_FILTER -- requirements
Module: coin_key_filter

Interface
REQ-001 SHALL have parameter CNT_MAX, default 999_999, meaning debounce length: a key level is accepted after CNT_MAX+1 consecutive stable synchronized samples (20 ms at 50 MHz).
REQ-002 SHALL have port sys_clk  input  1  the single clock; all flops on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port key_one_in  input  1  raw 1-yuan coin button, asynchronous, active-low, bouncing.
REQ-005 SHALL have port key_half_in  input  1  raw 0.5-yuan coin button, asynchronous, active-low, bouncing.
REQ-006 SHALL have port po_money_one  output  1  one-cycle pulse per accepted 1-yuan press; feeds the vending FSM pi_money_one.
REQ-007 SHALL have port po_money_half  output  1  one-cycle pulse per accepted 0.5-yuan press; feeds the vending FSM pi_money_half.

Function
REQ-008 SHALL pass each raw key through a 2-flop synchronizer; synchronizer flops reset to 1 (released).
REQ-009 SHALL debounce each key with an independent 4-state FSM: IDLE (released), PRESS_FLT, DOWN, REL_FLT, plus a counter of width ceil(log2(CNT_MAX+1)).
REQ-010 SHALL transition IDLE->PRESS_FLT with counter cleared when the synchronized key is 0; otherwise remain in IDLE.
REQ-011 SHALL in PRESS_FLT return to IDLE on any synchronized 1; increment while 0; on the sample where the counter equals CNT_MAX and the key is 0, go to DOWN and issue one internal press pulse.
REQ-012 SHALL in DOWN go to REL_FLT with counter cleared on synchronized 1; REL_FLT returns to DOWN on any 0 and reaches IDLE after CNT_MAX+1 consecutive 1 samples; no pulse on release.
REQ-013 SHALL set a pending flag pend_one/pend_half on each internal press pulse; the flag clears in the cycle its output pulse is issued.
REQ-014 SHALL each cycle issue at most one output pulse from the pending flags, priority pend_one over pend_half; po_money_one and po_money_half SHALL never be high in the same cycle.
REQ-015 SHALL register both outputs; latency from the first clock edge sampling a raw 0 (E0) to the output pulse, for a clean press with no contention, is exactly CNT_MAX+4 edges.
REQ-016 SHALL produce exactly one pulse per accepted press regardless of hold duration; bounces shorter than CNT_MAX+1 cycles produce no pulse and no extra pulse.
REQ-017 SHALL keep counters saturating-free by construction: the counter never exceeds CNT_MAX in any state.

Reset
REQ-018 SHALL on sys_rst=1 at a clock edge force both FSMs to DOWN, counters to 0, pending flags to 0, synchronizers to 1, po_money_one=0, po_money_half=0.
REQ-019 SHALL therefore require a debounced release after reset before any press is accepted; a key held through reset yields no pulse.
REQ-020 SHALL discard any in-progress filtering or pending pulse when reset is asserted mid-operation.

Configuration
REQ-021 SHALL, with COIN_ARB_DEFER_EN defined, defer the losing pend_half by one cycle when both flags are set (half pulse issued the cycle after the one pulse).
REQ-022 SHALL, without COIN_ARB_DEFER_EN, clear pend_half whenever pend_one is issued in the same cycle, so simultaneous presses yield only po_money_one.

Structure
REQ-023 SHALL place FSM state encodings (one-hot 4-bit IDLE, PRESS_FLT, DOWN, REL_FLT) in shared package coin_filter_pkg.
REQ-024 SHALL implement synchronizer+FSM+counter as sub-module key_filter (ports sys_clk, sys_rst, key_in, press_pulse, parameter CNT_MAX), instantiated twice; arbitration and pending flags live in the top.

Verification (CNT_MAX=4 in bench)
REQ-025 Clean press: reset released, key_one_in 1 for 12 cycles then 0 held -> single po_money_one pulse at edge E0+8, none thereafter while held.
REQ-026 Bounce: key_half_in low 3 cycles, high 1, low 3, high -> no pulse; then low held 10 cycles -> exactly one po_money_half pulse.
REQ-027 Simultaneous: both keys go low on the same edge after release-settled -> po_money_one at E0+8, po_money_half at E0+9 (defined) / no half pulse (undefined).
REQ-028 Held through reset: key_one_in 0 before and during 3-cycle sys_rst, held 20 cycles after -> no pulse; release 10 cycles, press again -> one pulse.
REQ-029 Reset mid-filter: key_one_in low, sys_rst asserted at E0+5 for 1 cycle -> no pulse, outputs 0 during reset.
REQ-030 Assertion throughout all scenarios: po_money_one & po_money_half never both 1; every pulse is exactly one cycle wide.
